// File: rtl/xor_share_arbiter_if.sv
// Requester-side bundle of the shared XOR arbiter: two request/operand
// ports in, one completion/result bus out.
interface xor_share_arbiter_if #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
);
  logic               req0;
  logic [WIDTH-1:0]   a0;
  logic [WIDTH-1:0]   b0;
  logic               req1;
  logic [WIDTH-1:0]   a1;
  logic [WIDTH-1:0]   b1;
  logic               done0;
  logic               done1;
  logic [WIDTH-1:0]   res;
  logic               res_id;
  logic               busy;
  logic [COUNT_W-1:0] op_count;

  // Requesting units drive requests/operands and observe completion.
  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  done0, done1, res, res_id, busy, op_count
  );

  // The arbiter consumes requests/operands and reports completion.
  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output done0, done1, res, res_id, busy, op_count
  );
endinterface

// File: rtl/xor_share_arbiter.sv
// Round-robin arbiter sharing one XOR datapath between two requesters.
// IDLE grants and latches operands, EXEC registers the result, DONE
// pulses done for the winner and bumps the completion counter.
module xor_share_arbiter #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
) (
  input logic                clk,
  input logic                rst_n,
  xor_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               grant_id_q, grant_id_d;
  logic               last_grant_q, last_grant_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               res_id_q, res_id_d;
  logic [COUNT_W-1:0] op_count_q, op_count_d;

  logic               any_req;
  logic               pick;

  // Round-robin pick: a lone request wins outright; on a tie the requester
  // that did not win last time is chosen.
  always_comb begin
    any_req = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) begin
      pick = ~last_grant_q;
    end else begin
      pick = bus.req1;
    end
  end

  // State register; last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
      opa_q        <= '0;
      opb_q        <= '0;
      res_q        <= '0;
      res_id_q     <= 1'b0;
      op_count_q   <= '0;
    end else begin
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      res_q        <= res_d;
      res_id_q     <= res_id_d;
      op_count_q   <= op_count_d;
    end
  end

  // Next-state and next-datapath logic; operands are latched only on the
  // grant edge so the ports may change freely afterwards.
  always_comb begin
    // NOTE: every target gets a hold default first so no path leaves a
    // variable unassigned and no latch is inferred.
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    res_d        = res_q;
    res_id_d     = res_id_q;
    op_count_d   = op_count_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          grant_id_d   = pick;
          last_grant_d = pick;
          opa_d        = pick ? bus.a1 : bus.a0;
          opb_d        = pick ? bus.b1 : bus.b0;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        res_d    = opa_q ^ opb_q;
        res_id_d = grant_id_q;
        state_d  = S_DONE;
      end
      S_DONE: begin
        op_count_d = op_count_q + COUNT_W'(1);
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: done is decoded from DONE so it lasts exactly one cycle and
  // drops immediately on an asynchronous reset.
  always_comb begin
    bus.done0    = (state_q == S_DONE) && !grant_id_q;
    bus.done1    = (state_q == S_DONE) &&  grant_id_q;
    bus.busy     = (state_q != S_IDLE);
    bus.res      = res_q;
    bus.res_id   = res_id_q;
    bus.op_count = op_count_q;
  end

endmodule

// File: tb/tb_xor_share_arbiter.sv
// Self-checking bench for xor_share_arbiter: a default-sized instance plus
// a WIDTH=1 instance and a COUNT_W=2 instance for the boundary scenarios.
module tb_xor_share_arbiter;

  logic clk;
  logic rst_n;

  xor_share_arbiter_if #(.WIDTH(8), .COUNT_W(8)) m_if ();
  xor_share_arbiter_if #(.WIDTH(1), .COUNT_W(8)) w_if ();
  xor_share_arbiter_if #(.WIDTH(8), .COUNT_W(2)) c_if ();

  xor_share_arbiter #(.WIDTH(8), .COUNT_W(8)) u_main (.clk(clk), .rst_n(rst_n), .bus(m_if));
  xor_share_arbiter #(.WIDTH(1), .COUNT_W(8)) u_w1   (.clk(clk), .rst_n(rst_n), .bus(w_if));
  xor_share_arbiter #(.WIDTH(8), .COUNT_W(2)) u_c2   (.clk(clk), .rst_n(rst_n), .bus(c_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       id;
    logic [7:0] res;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  localparam int BUDGET = 20;

  // Waits (bounded) on negedges for a done pulse from the selected instance
  // and returns what was observed in that cycle.
  task automatic wait_done(input int sel, output bit ok, output logic d0,
                           output logic d1, output logic [7:0] r,
                           output logic rid, output int cyc);
    ok = 1'b0; d0 = 1'b0; d1 = 1'b0; r = '0; rid = 1'b0; cyc = -1;
    for (int i = 1; i <= BUDGET; i++) begin
      @(negedge clk);
      case (sel)
        0: begin d0 = m_if.done0; d1 = m_if.done1; r = m_if.res; rid = m_if.res_id; end
        1: begin d0 = w_if.done0; d1 = w_if.done1; r = {7'b0, w_if.res}; rid = w_if.res_id; end
        default: begin d0 = c_if.done0; d1 = c_if.done1; r = c_if.res; rid = c_if.res_id; end
      endcase
      if (d0 || d1) begin
        ok = 1'b1; cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (m_if.done0 !== 1'b0) $display("FAIL reset_done0: got %b, expected 0", m_if.done0); else pass_cnt++;
    total_cnt++; if (m_if.done1 !== 1'b0) $display("FAIL reset_done1: got %b, expected 0", m_if.done1); else pass_cnt++;
    total_cnt++; if (m_if.res !== 8'h00) $display("FAIL reset_res: got %h, expected 00", m_if.res); else pass_cnt++;
    total_cnt++; if (m_if.res_id !== 1'b0) $display("FAIL reset_res_id: got %b, expected 0", m_if.res_id); else pass_cnt++;
    total_cnt++; if (m_if.busy !== 1'b0) $display("FAIL reset_busy: got %b, expected 0", m_if.busy); else pass_cnt++;
    total_cnt++; if (m_if.op_count !== 8'd0) $display("FAIL reset_op_count: got %0d, expected 0", m_if.op_count); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    bit ok; logic d0, d1, rid; logic [7:0] r; int cyc; exp_t e;
    @(posedge clk); #1;
    m_if.req0 = 1'b1; m_if.a0 = 8'hF0; m_if.b0 = 8'h3C;
    sb_q.push_back('{id: 1'b0, res: 8'hCC});
    wait_done(0, ok, d0, d1, r, rid, cyc);
    m_if.req0 = 1'b0;
    e = sb_q.pop_front();
    total_cnt++; if (!ok) $display("FAIL single_timeout: no done within %0d cycles", BUDGET); else pass_cnt++;
    total_cnt++; if (cyc !== 3) $display("FAIL single_latency: got %0d, expected 3", cyc); else pass_cnt++;
    total_cnt++; if (d0 !== !e.id || d1 !== e.id) $display("FAIL single_done: got d0=%b d1=%b, expected id %b", d0, d1, e.id); else pass_cnt++;
    total_cnt++; if (r !== e.res) $display("FAIL single_res: got %h, expected %h", r, e.res); else pass_cnt++;
    total_cnt++; if (rid !== e.id) $display("FAIL single_res_id: got %b, expected %b", rid, e.id); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (m_if.op_count !== 8'd1) $display("FAIL single_op_count: got %0d, expected 1", m_if.op_count); else pass_cnt++;
    total_cnt++; if (m_if.busy !== 1'b0) $display("FAIL single_busy_idle: got %b, expected 0", m_if.busy); else pass_cnt++;
  endtask

  task automatic test_both_alternate();
    bit ok; logic d0, d1, rid; logic [7:0] r; int cyc; exp_t e;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    m_if.req0 = 1'b1; m_if.a0 = 8'hFF; m_if.b0 = 8'h0F;
    m_if.req1 = 1'b1; m_if.a1 = 8'hAA; m_if.b1 = 8'h55;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) sb_q.push_back('{id: 1'b0, res: 8'hF0});
      else            sb_q.push_back('{id: 1'b1, res: 8'hFF});
    end
    for (int i = 0; i < 6; i++) begin
      wait_done(0, ok, d0, d1, r, rid, cyc);
      if (i == 5) begin m_if.req0 = 1'b0; m_if.req1 = 1'b0; end
      e = sb_q.pop_front();
      total_cnt++;
      if (!ok || d0 !== !e.id || d1 !== e.id || r !== e.res || rid !== e.id)
        $display("FAIL both_op%0d: got ok=%b d0=%b d1=%b res=%h id=%b, expected id=%b res=%h",
                 i, ok, d0, d1, r, rid, e.id, e.res);
      else pass_cnt++;
    end
    @(posedge clk); #1;
    total_cnt++; if (m_if.op_count !== 8'd6) $display("FAIL both_op_count: got %0d, expected 6", m_if.op_count); else pass_cnt++;
  endtask

  task automatic test_width1_exhaustive();
    bit ok; logic d0, d1, rid; logic [7:0] r; int cyc; exp_t e;
    logic [3:0] tbl;
    tbl = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      w_if.req1 = 1'b1; w_if.a1 = 1'(i >> 1); w_if.b1 = 1'(i);
      sb_q.push_back('{id: 1'b1, res: {7'b0, tbl[i]}});
      wait_done(1, ok, d0, d1, r, rid, cyc);
      w_if.req1 = 1'b0;
      e = sb_q.pop_front();
      total_cnt++;
      if (!ok || d1 !== 1'b1 || d0 !== 1'b0 || r !== e.res || rid !== 1'b1)
        $display("FAIL w1_pair%0d: got ok=%b d0=%b d1=%b res=%h id=%b, expected res=%h id=1",
                 i, ok, d0, d1, r, rid, e.res);
      else pass_cnt++;
    end
  endtask

  task automatic test_withdraw_exec();
    bit ok; logic d0, d1, rid; logic [7:0] r; int cyc; exp_t e; int busy_seen;
    @(posedge clk); #1;
    m_if.req0 = 1'b1; m_if.a0 = 8'h5A; m_if.b0 = 8'h33;
    sb_q.push_back('{id: 1'b0, res: 8'h69});
    @(posedge clk); #1;
    m_if.req0 = 1'b0; m_if.a0 = 8'h00; m_if.b0 = 8'h00;
    wait_done(0, ok, d0, d1, r, rid, cyc);
    e = sb_q.pop_front();
    total_cnt++;
    if (!ok || d0 !== 1'b1 || d1 !== 1'b0 || r !== e.res || rid !== 1'b0)
      $display("FAIL withdraw_done: got ok=%b d0=%b d1=%b res=%h id=%b, expected res=%h id=0",
               ok, d0, d1, r, rid, e.res);
    else pass_cnt++;
    busy_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (m_if.busy) busy_seen++;
    end
    total_cnt++; if (busy_seen != 0) $display("FAIL withdraw_regrant: got %0d busy cycles, expected 0", busy_seen); else pass_cnt++;
    total_cnt++; if (m_if.res !== 8'h69) $display("FAIL withdraw_res_hold: got %h, expected 69", m_if.res); else pass_cnt++;
    total_cnt++; if (m_if.op_count !== 8'd7) $display("FAIL withdraw_op_count: got %0d, expected 7", m_if.op_count); else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    bit ok; logic d0, d1, rid; logic [7:0] r; int cyc; exp_t e; int done_seen;
    @(posedge clk); #1;
    m_if.req1 = 1'b1; m_if.a1 = 8'h12; m_if.b1 = 8'h34;
    @(posedge clk); #1;
    total_cnt++; if (m_if.busy !== 1'b1) $display("FAIL midrst_busy_exec: got %b, expected 1", m_if.busy); else pass_cnt++;
    #1 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (m_if.busy !== 1'b0 || m_if.res !== 8'h00 || m_if.res_id !== 1'b0 || m_if.op_count !== 8'd0)
      $display("FAIL midrst_async: got busy=%b res=%h id=%b cnt=%0d, expected 0/00/0/0",
               m_if.busy, m_if.res, m_if.res_id, m_if.op_count);
    else pass_cnt++;
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (m_if.done0 || m_if.done1) done_seen++;
    end
    total_cnt++; if (done_seen != 0) $display("FAIL midrst_no_done: got %0d done cycles, expected 0", done_seen); else pass_cnt++;
    #1 rst_n = 1'b1;
    sb_q.push_back('{id: 1'b1, res: 8'h26});
    wait_done(0, ok, d0, d1, r, rid, cyc);
    m_if.req1 = 1'b0;
    e = sb_q.pop_front();
    total_cnt++;
    if (!ok || d1 !== 1'b1 || d0 !== 1'b0 || r !== e.res || rid !== 1'b1)
      $display("FAIL midrst_after: got ok=%b d0=%b d1=%b res=%h id=%b, expected res=%h id=1",
               ok, d0, d1, r, rid, e.res);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (m_if.op_count !== 8'd1) $display("FAIL midrst_op_count: got %0d, expected 1", m_if.op_count); else pass_cnt++;
  endtask

  task automatic test_counter_wrap();
    bit ok; logic d0, d1, rid; logic [7:0] r; int cyc;
    int cnt_exp[5] = '{1, 2, 3, 0, 1};
    @(posedge clk); #1;
    c_if.req0 = 1'b1; c_if.a0 = 8'h0F; c_if.b0 = 8'hF0;
    for (int i = 0; i < 5; i++) begin
      wait_done(2, ok, d0, d1, r, rid, cyc);
      if (i == 4) c_if.req0 = 1'b0;
      total_cnt++;
      if (!ok || d0 !== 1'b1 || r !== 8'hFF)
        $display("FAIL wrap_done%0d: got ok=%b d0=%b res=%h, expected done0 res=ff", i, ok, d0, r);
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (c_if.op_count !== 2'(cnt_exp[i]))
        $display("FAIL wrap_count%0d: got %0d, expected %0d", i, c_if.op_count, cnt_exp[i]);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    m_if.req0 = 1'b0; m_if.a0 = '0; m_if.b0 = '0;
    m_if.req1 = 1'b0; m_if.a1 = '0; m_if.b1 = '0;
    w_if.req0 = 1'b0; w_if.a0 = '0; w_if.b0 = '0;
    w_if.req1 = 1'b0; w_if.a1 = '0; w_if.b1 = '0;
    c_if.req0 = 1'b0; c_if.a0 = '0; c_if.b0 = '0;
    c_if.req1 = 1'b0; c_if.a1 = '0; c_if.b1 = '0;
    test_reset();
    test_single();
    test_both_alternate();
    test_width1_exhaustive();
    test_withdraw_exec();
    test_reset_mid_op();
    test_counter_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/xor_share_arbiter.md
Name: xor_share_arbiter

Overview:
- Shares one WIDTH-bit XOR datapath (s = a ^ b) between two requesters, using round-robin arbitration and a req/done handshake.
- Operands are latched on grant, the result is registered, and completion is signalled by a one-cycle done pulse to the winning requester.
- A wrap-around counter records completed operations for bench and debug visibility.
- Sits between the requesting units and the single combinational XOR block.

Parameters:
- WIDTH, 8, operand and result width in bits.
- COUNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 request; held high until done0.
- a0  input  WIDTH  requester 0 operand a.
- b0  input  WIDTH  requester 0 operand b.
- req1  input  1  requester 1 request; held high until done1.
- a1  input  WIDTH  requester 1 operand a.
- b1  input  WIDTH  requester 1 operand b.
- done0  output  1  one-cycle pulse: requester 0 result valid on res.
- done1  output  1  one-cycle pulse: requester 1 result valid on res.
- res  output  WIDTH  registered XOR result; held until the next result.
- res_id  output  1  owner of the current res (0 or 1).
- busy  output  1  high while the FSM is not IDLE.
- op_count  output  COUNT_W  number of completed operations; wraps around.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE, done0=done1=0, res=0, res_id=0, busy=0, op_count=0, last_grant=1 (so requester 0 wins the first tie).
- FSM states: IDLE, EXEC, DONE.
- IDLE, no request: no request asserted -> stay in IDLE.
- IDLE, one request: exactly one req high -> grant that requester.
- IDLE, both requests: both req high -> grant the requester that is not last_grant.
- IDLE, on the grant edge: latch opa/opb from the granted port, set grant_id, set last_grant=grant_id, go to EXEC.
- EXEC: on the edge, res <= opa ^ opb, res_id <= grant_id, done[grant_id] <= 1, go to DONE.
- DONE:
  - done[grant_id] is high for exactly this one cycle.
  - On the edge: clear done, op_count <= op_count+1 (modulo 2^COUNT_W), go to IDLE.
- Latency: req sampled high in cycle N -> done pulse in cycle N+2 -> earliest next grant sampled in cycle N+3.
- Throughput: one operation per 3 cycles.
- busy: high in EXEC and DONE.
- Operand stability: the port operands may change after the grant edge; only the latched values are used.
- Request dropped during EXEC or DONE: the operation still completes and done still pulses. A dropped request is never cancelled.
- Request still high in the IDLE cycle after done: treated as a new request and arbitrated normally.
- Continuous requests from both ports: grants strictly alternate 0,1,0,1,...
- Starvation: none; a waiting requester is served within one operation.
- res and res_id: hold their value in IDLE and are never cleared except by reset.
- op_count: at 2^COUNT_W-1 it wraps to 0 on the next completion.
- Reset mid-operation: immediate return to reset values; the in-flight operation is discarded, no done pulse, op_count unchanged from 0.
- done0 and done1: never high simultaneously.

Test Plan:
- Single requester: req0=1, a0=8'hF0, b0=8'h3C -> done0 pulses 2 cycles after the sample; res=8'hCC, res_id=0, op_count=1, done1 stays 0.
- Simultaneous requests after reset: req0=req1=1, a0=8'hFF, b0=8'h0F, a1=8'hAA, b1=8'h55.
  - First done0 with res=8'hF0.
  - Then done1 with res=8'hFF, res_id=1.
  - Grants alternate over 6 operations; op_count=6.
- Exhaustive 1-bit (WIDTH=1): operand pairs 00, 01, 10, 11 on req1 -> res = 0, 1, 1, 0 respectively.
- Request withdrawn in EXEC: req0 drops one cycle after the grant -> done0 still pulses with the correct res; the FSM returns to IDLE with no further grant.
- Reset mid-operation: assert rst_n=0 during EXEC -> outputs return to reset values asynchronously and no done pulse occurs. After release, req1 alone is granted normally.
- Counter wrap (COUNT_W=2): 5 back-to-back operations -> op_count sequence 1, 2, 3, 0, 1.
